// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types for the data-memory port arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        ST_OPEN    = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    localparam logic [3:0] BE_NONE = 4'b0000;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        sgn;
    } req_t;

endpackage

// File: rtl/dm_arb_sat_ctr.sv
// rtl/dm_arb_sat_ctr.sv - saturating up-counter with synchronous clear.
module dm_arb_sat_ctr #(
    parameter int unsigned W   = 8,
    parameter int unsigned MAX = 255
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;

    // Clear wins over increment.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - CPU/DMA arbiter for the MMU data-memory port.
// Optional stall counters are built when DM_ARB_PERF_EN is defined.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    input  logic        cpu_signed,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_be,
    input  logic        dma_signed,
    input  logic        dma_lock,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_signed,
`ifdef DM_ARB_PERF_EN
    output logic [15:0] perf_cpu_stall,
    output logic [15:0] perf_dma_stall,
`endif
    input  logic [31:0] mem_rdata
);
    state_e     state_q, state_d;
    owner_e     owner_q, win, open_win;
    logic       we_q;
    logic [7:0] wait_cnt, lock_cnt;
    logic       dma_forced, lock_last;
    req_t       cpu_bundle, dma_bundle, mem_bundle;

    assign cpu_bundle = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, be: cpu_be, sgn: cpu_signed};
    assign dma_bundle = '{we: dma_we, addr: dma_addr, wdata: dma_wdata, be: dma_be, sgn: dma_signed};

    assign dma_forced = dma_req && (wait_cnt == 8'(MAX_WAIT));
    // True when the current DMA grant would be the last beat a lock may take.
    assign lock_last  = (({1'b0, lock_cnt} + 9'd1) == 9'(LOCK_MAX));

    always_comb begin
        open_win = OWN_NONE;
        if (cpu_req && !dma_forced) begin
            open_win = OWN_CPU;
        end else if (dma_req) begin
            open_win = OWN_DMA;
        end
    end

    always_comb begin
        win     = open_win;
        state_d = ST_OPEN;
        case (state_q)
            ST_LOCKED:  if (dma_req && dma_lock) win = OWN_DMA;
            ST_RELEASE: win = cpu_req ? OWN_CPU : OWN_NONE;
            default:    win = open_win;
        endcase
        // RELEASE never grants DMA, so a locked DMA grant always (re)enters or extends a lock.
        if ((win == OWN_DMA) && dma_lock) begin
            state_d = lock_last ? ST_RELEASE : ST_LOCKED;
        end
    end

    always_comb begin
        mem_bundle    = '0;
        mem_bundle.be = BE_NONE;
        case (win)
            OWN_CPU: mem_bundle = cpu_bundle;
            OWN_DMA: mem_bundle = dma_bundle;
            default: mem_bundle = '0;
        endcase
    end

    assign cpu_gnt    = (win == OWN_CPU);
    assign dma_gnt    = (win == OWN_DMA);
    assign mem_we     = mem_bundle.we;
    assign mem_addr   = mem_bundle.addr;
    assign mem_wdata  = mem_bundle.wdata;
    assign mem_be     = mem_bundle.be;
    assign mem_signed = mem_bundle.sgn;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_OPEN;
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= win;
            we_q    <= mem_bundle.we;
        end
    end

    assign cpu_rvalid = (owner_q == OWN_CPU);
    assign dma_rvalid = (owner_q == OWN_DMA);
    assign cpu_rdata  = (cpu_rvalid && !we_q) ? mem_rdata : 32'd0;
    assign dma_rdata  = (dma_rvalid && !we_q) ? mem_rdata : 32'd0;

    dm_arb_sat_ctr #(.W(8), .MAX(MAX_WAIT)) u_wait_ctr (
        .clk    (clk),
        .resetb (resetb),
        .inc_i  (dma_req && !dma_gnt),
        .clr_i  (!dma_req || dma_gnt),
        .cnt_o  (wait_cnt)
    );

    dm_arb_sat_ctr #(.W(8), .MAX(LOCK_MAX)) u_lock_ctr (
        .clk    (clk),
        .resetb (resetb),
        .inc_i  (state_d == ST_LOCKED),
        .clr_i  (state_d != ST_LOCKED),
        .cnt_o  (lock_cnt)
    );

`ifdef DM_ARB_PERF_EN
    dm_arb_sat_ctr #(.W(16), .MAX(16'hFFFF)) u_perf_cpu (
        .clk    (clk),
        .resetb (resetb),
        .inc_i  (cpu_req && !cpu_gnt),
        .clr_i  (1'b0),
        .cnt_o  (perf_cpu_stall)
    );

    dm_arb_sat_ctr #(.W(16), .MAX(16'hFFFF)) u_perf_dma (
        .clk    (clk),
        .resetb (resetb),
        .inc_i  (dma_req && !dma_gnt),
        .clr_i  (1'b0),
        .cnt_o  (perf_dma_stall)
    );
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - self-checking bench for dm_port_arbiter.
module tb_dm_port_arbiter;
    localparam int MW = 8;
    localparam int LM = 4;

    logic        clk = 1'b0;
    logic        resetb;
    logic        c_req, c_we, c_sgn, d_req, d_we, d_sgn, d_lock;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata, mem_rdata;
    logic [3:0]  c_be, d_be;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_we, mem_signed;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
`ifdef DM_ARB_PERF_EN
    logic [15:0] perf_cpu_stall, perf_dma_stall;
`endif

    always #5 clk = ~clk;

    dm_port_arbiter #(.MAX_WAIT(MW), .LOCK_MAX(LM)) dut (
        .clk(clk), .resetb(resetb),
        .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr), .cpu_wdata(c_wdata),
        .cpu_be(c_be), .cpu_signed(c_sgn), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .dma_req(d_req), .dma_we(d_we), .dma_addr(d_addr), .dma_wdata(d_wdata),
        .dma_be(d_be), .dma_signed(d_sgn), .dma_lock(d_lock), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_signed(mem_signed),
`ifdef DM_ARB_PERF_EN
        .perf_cpu_stall(perf_cpu_stall), .perf_dma_stall(perf_dma_stall),
`endif
        .mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 open, 1 locked, 2 release; owner 0 none, 1 cpu, 2 dma.
    int m_mode, m_wait, m_beats, m_owner, m_cst, m_dst, cur_w;
    bit m_we;

    typedef struct {
        bit cr, dr, dl, ecg, edg;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_beats = 0; m_owner = 0; m_we = 0; m_cst = 0; m_dst = 0;
    endtask

    function automatic int pick();
        bit forced;
        forced = d_req && (m_wait >= MW);
        if (m_mode == 1 && d_req && d_lock) return 2;
        if (m_mode == 2) return c_req ? 1 : 0;
        if (c_req && !forced) return 1;
        if (d_req) return 2;
        return 0;
    endfunction

    task automatic model_update();
        if (cur_w == 2 && d_lock && m_mode != 2) begin
            m_beats = (m_mode == 1) ? m_beats + 1 : 1;
            if (m_beats >= LM) begin m_mode = 2; m_beats = 0; end
            else m_mode = 1;
        end else begin
            m_mode = 0; m_beats = 0;
        end
        m_wait = (d_req && cur_w != 2) ? ((m_wait < MW) ? m_wait + 1 : MW) : 0;
        if (c_req && cur_w != 1 && m_cst < 65535) m_cst++;
        if (d_req && cur_w != 2 && m_dst < 65535) m_dst++;
        m_owner = cur_w;
        m_we = (cur_w == 1) ? c_we : (cur_w == 2) ? d_we : 1'b0;
    endtask

    task automatic drive(input bit cr, input bit dr, input bit dl);
        @(negedge clk);
        c_req = cr; d_req = dr; d_lock = dl;
        c_we = 1'($urandom_range(0, 1)); c_addr = $urandom; c_wdata = $urandom;
        c_be = 4'($urandom_range(0, 15)); c_sgn = 1'($urandom_range(0, 1));
        d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
        d_be = 4'($urandom_range(0, 15)); d_sgn = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
    endtask

    task automatic eval_cyc();
        logic [70:0] exp_bus;
        #4;
        cur_w = pick();
        chk("cpu_gnt", 32'(cpu_gnt), 32'(cur_w == 1));
        chk("dma_gnt", 32'(dma_gnt), 32'(cur_w == 2));
        exp_bus = (cur_w == 1) ? {c_we, c_addr, c_wdata, c_be, c_sgn} :
                  (cur_w == 2) ? {d_we, d_addr, d_wdata, d_be, d_sgn} : '0;
        chk("mem_addr", mem_addr, exp_bus[68:37]);
        chk("mem_ctl", {25'd0, mem_we, mem_be, mem_signed, 1'b0},
            {25'd0, exp_bus[69], exp_bus[4:1], exp_bus[0], 1'b0});
        chk("mem_wdata", mem_wdata, exp_bus[36:5]);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_owner == 1));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(m_owner == 2));
        chk("cpu_rdata", cpu_rdata, (m_owner == 1 && !m_we) ? mem_rdata : 32'd0);
        chk("dma_rdata", dma_rdata, (m_owner == 2 && !m_we) ? mem_rdata : 32'd0);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        c_req = 0; d_req = 0; d_lock = 0; c_we = 0; d_we = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetb = 1'b1;
        model_reset();
    endtask

    initial begin
        resetb = 1'b0;
        c_req = 0; d_req = 0; d_lock = 0; c_we = 0; d_we = 0; c_sgn = 0; d_sgn = 0;
        c_addr = 0; d_addr = 0; c_wdata = 0; d_wdata = 0; c_be = 0; d_be = 0; mem_rdata = 32'hA5A5A5A5;
        model_reset();
        #12;
        chk("rst_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 32'd0);
        chk("rst_rdata", cpu_rdata | dma_rdata, 32'd0);
        chk("rst_mem", {27'd0, mem_we, mem_be}, 32'd0);
        do_reset();

        // Starvation, lock burst, release, relock and lock exit.
        for (int i = 0; i < 8; i++) tbl[i] = '{1, 1, 0, 1, 0};
        tbl[8]  = '{1, 1, 0, 0, 1};
        tbl[9]  = '{1, 1, 0, 1, 0};
        tbl[10] = '{0, 1, 1, 0, 1};
        for (int i = 11; i < 14; i++) tbl[i] = '{1, 1, 1, 0, 1};
        tbl[14] = '{1, 1, 1, 1, 0};
        tbl[15] = '{0, 1, 1, 0, 1};
        tbl[16] = '{1, 0, 1, 1, 0};
        tbl[17] = '{0, 0, 0, 0, 0};
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].cr, tbl[i].dr, tbl[i].dl);
            eval_cyc();
            chk($sformatf("tbl%0d_cgnt", i), 32'(cpu_gnt), 32'(tbl[i].ecg));
            chk($sformatf("tbl%0d_dgnt", i), 32'(dma_gnt), 32'(tbl[i].edg));
            advance();
        end

        // CPU read with one-cycle response.
        drive(1, 0, 0);
        c_we = 0; c_addr = 32'h10000004; c_be = 4'hF;
        eval_cyc();
        chk("rd_gnt", 32'(cpu_gnt), 32'd1);
        chk("rd_addr", mem_addr, 32'h10000004);
        chk("rd_be", 32'(mem_be), 32'hF);
        advance();
        drive(0, 0, 0);
        mem_rdata = 32'hDEADBEEF;
        eval_cyc();
        chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd_dvalid", 32'(dma_rvalid), 32'd0);
        advance();

        // DMA write then CPU read, back-to-back responses.
        drive(0, 1, 0);
        d_we = 1; d_be = 4'b0001;
        eval_cyc();
        chk("wr_dgnt", 32'(dma_gnt), 32'd1);
        advance();
        drive(1, 0, 0);
        c_we = 0;
        eval_cyc();
        chk("wr_dvalid", 32'(dma_rvalid), 32'd1);
        chk("wr_drdata", dma_rdata, 32'd0);
        chk("wr_cgnt", 32'(cpu_gnt), 32'd1);
        advance();
        drive(0, 0, 0);
        eval_cyc();
        chk("wr_cvalid", 32'(cpu_rvalid), 32'd1);
        chk("wr_crdata", cpu_rdata, mem_rdata);
        advance();

        // Reset right after a CPU grant drops the pending response.
        drive(1, 0, 0);
        eval_cyc();
        advance();
        #1 resetb = 1'b0;
        #1 chk("rstmid_rvalid", 32'(cpu_rvalid), 32'd0);
        do_reset();
        drive(0, 0, 0);
        eval_cyc();
        chk("post_rst_out", {26'd0, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_we, |mem_be}, 32'd0);
        advance();
        drive(1, 1, 1);
        eval_cyc();
        chk("post_rst_open", 32'(cpu_gnt), 32'd1);
        advance();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 4) < 3);
            eval_cyc();
            advance();
        end

`ifdef DM_ARB_PERF_EN
        #1;
        chk("perf_cpu_rand", 32'(perf_cpu_stall), 32'(m_cst));
        chk("perf_dma_rand", 32'(perf_dma_stall), 32'(m_dst));
        do_reset();
        drive(0, 1, 1); eval_cyc(); advance();
        for (int i = 0; i < 3; i++) begin drive(1, 1, 1); eval_cyc(); advance(); end
        drive(1, 1, 1); eval_cyc(); advance();
        drive(0, 1, 1); eval_cyc(); advance();
        for (int i = 0; i < 2; i++) begin drive(1, 1, 1); eval_cyc(); advance(); end
        drive(0, 0, 0); eval_cyc();
        chk("perf_cpu5", 32'(perf_cpu_stall), 32'd5);
        chk("perf_dma1", 32'(perf_dma_stall), 32'd1);
        advance();
        do_reset();
        @(negedge clk);
        c_req = 1; d_req = 1; d_lock = 0;
        repeat (75000) @(posedge clk);
        #1 chk("perf_dma_sat", 32'(perf_dma_stall), 32'hFFFF);
        do_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
